// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] REG_ZERO = '0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy tracking: flush > issue set > writeback clear, plus registered busy count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     i_IssueValid,
  input  logic [ADDR_W-1:0]        i_IssueRd,
  input  logic                     i_Flush,
  input  logic [NUM_WR-1:0]        i_WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] i_WrAddr,
  output logic [(2**ADDR_W)-1:0]   o_Busy,
  output logic [ADDR_W:0]          o_BusyCnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_d;
  logic [ADDR_W:0]    r_busy_cnt;
  logic [ADDR_W:0]    w_cnt_d;

  always_comb begin
    w_busy_d = r_busy;
    for (int r = 1; r < NumRegs; r++) begin
      if (i_Flush) begin
        w_busy_d[r] = 1'b0;
      end else if (i_IssueValid && (i_IssueRd == ADDR_W'(r))) begin
        // A new producer wins over a same-cycle writeback of the old one.
        w_busy_d[r] = 1'b1;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_WrEn[w] && (i_WrAddr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            w_busy_d[r] = 1'b0;
          end
        end
      end
    end
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_cnt_d = '0;
    for (int r = 0; r < NumRegs; r++) begin
      w_cnt_d = w_cnt_d + (ADDR_W+1)'(w_busy_d[r]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_cnt_d;
    end
  end

  assign o_Busy    = r_busy;
  assign o_BusyCnt = r_busy_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with scoreboard; x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD-1:0]        i_RdEn,
  input  logic [NUM_RD*ADDR_W-1:0] i_RdAddr,
  output logic [NUM_RD*DATA_W-1:0] o_RdData,
  output logic [NUM_RD-1:0]        o_RdBusy,
  input  logic [NUM_WR-1:0]        i_WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] i_WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] i_WrData,
  input  logic                     i_IssueValid,
  input  logic [ADDR_W-1:0]        i_IssueRd,
  input  logic                     i_Flush,
  output logic [ADDR_W:0]          o_BusyCnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_mem [NumRegs];
  logic [NumRegs-1:0] w_busy;
  logic [ADDR_W-1:0]  w_ra;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_IssueValid (i_IssueValid),
    .i_IssueRd    (i_IssueRd),
    .i_Flush      (i_Flush),
    .i_WrEn       (i_WrEn),
    .i_WrAddr     (i_WrAddr),
    .o_Busy       (w_busy),
    .o_BusyCnt    (o_BusyCnt)
  );

  // Ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_WrEn[w] && (i_WrAddr[w*ADDR_W +: ADDR_W] != '0)) begin
          r_mem[i_WrAddr[w*ADDR_W +: ADDR_W]] <= i_WrData[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    o_RdData = '0;
    o_RdBusy = '0;
    w_ra     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_ra = i_RdAddr[p*ADDR_W +: ADDR_W];
      if (i_RdEn[p]) begin
        o_RdData[p*DATA_W +: DATA_W] = r_mem[w_ra];
        o_RdBusy[p]                  = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_WrEn[w] && (i_WrAddr[w*ADDR_W +: ADDR_W] == w_ra) && (w_ra != '0)) begin
            o_RdData[p*DATA_W +: DATA_W] = i_WrData[w*DATA_W +: DATA_W];
            o_RdBusy[p] = i_IssueValid && !i_Flush && (i_IssueRd == w_ra);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb; expectations are queued by stimulus and checked by a monitor.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NR-1:0]    RdEn;
  logic [NR*AW-1:0] RdAddr;
  logic [NR*DW-1:0] RdData;
  logic [NR-1:0]    RdBusy;
  logic [NW-1:0]    WrEn;
  logic [NW*AW-1:0] WrAddr;
  logic [NW*DW-1:0] WrData;
  logic             IssueValid;
  logic [AW-1:0]    IssueRd;
  logic             Flush;
  logic [AW:0]      BusyCnt;

  regfile_mp_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_RdEn       (RdEn),
    .i_RdAddr     (RdAddr),
    .o_RdData     (RdData),
    .o_RdBusy     (RdBusy),
    .i_WrEn       (WrEn),
    .i_WrAddr     (WrAddr),
    .i_WrData     (WrData),
    .i_IssueValid (IssueValid),
    .i_IssueRd    (IssueRd),
    .i_Flush      (Flush),
    .o_BusyCnt    (BusyCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int unsigned cyc;
    bit          is_cnt;
    int          port;
    logic [DW-1:0] data;
    logic        busy;
    logic [AW:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (e.is_cnt) begin
        if (BusyCnt !== e.cnt) begin
          fails++;
          $display("FAIL %s: BusyCnt got %0d want %0d", e.name, BusyCnt, e.cnt);
        end
      end else begin
        if (RdData[e.port*DW +: DW] !== e.data) begin
          fails++;
          $display("FAIL %s: RdData[%0d] got %h want %h", e.name, e.port,
                   RdData[e.port*DW +: DW], e.data);
        end
        tests++;
        if (RdBusy[e.port] !== e.busy) begin
          fails++;
          $display("FAIL %s: RdBusy[%0d] got %b want %b", e.name, e.port,
                   RdBusy[e.port], e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    RdEn       = '0;
    WrEn       = '0;
    IssueValid = 1'b0;
    IssueRd    = '0;
    Flush      = 1'b0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    RdEn[p]            = 1'b1;
    RdAddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    WrEn[w]            = 1'b1;
    WrAddr[w*AW +: AW] = a;
    WrData[w*DW +: DW] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    IssueValid = 1'b1;
    IssueRd    = a;
  endtask

  task automatic exp_rd(input string n, input int p, input logic [DW-1:0] d, input logic b);
    exp_t x;
    x.name = n; x.cyc = cyc; x.is_cnt = 1'b0; x.port = p;
    x.data = d; x.busy = b; x.cnt = '0;
    q.push_back(x);
  endtask

  task automatic exp_cnt(input string n, input logic [AW:0] c);
    exp_t x;
    x.name = n; x.cyc = cyc; x.is_cnt = 1'b1; x.port = 0;
    x.data = '0; x.busy = 1'b0; x.cnt = c;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst    = 1'b0;
    RdAddr = '0;
    WrAddr = '0;
    WrData = '0;
    clr();
    tick();
    tick();
    rd(0, 5); rd(1, 31);
    exp_rd("rst_rd0", 0, REG_ZERO, 1'b0);
    exp_rd("rst_rd1", 1, REG_ZERO, 1'b0);
    exp_cnt("rst_cnt", 0);
    tick();
    Rst = 1'b1;

    for (int a = 0; a < 32; a++) begin
      tick(); clr();
      rd(0, AW'(a)); rd(1, AW'(31 - a));
      exp_rd("init_p0", 0, REG_ZERO, 1'b0);
      exp_rd("init_p1", 1, REG_ZERO, 1'b0);
      exp_cnt("init_cnt", 0);
    end

    // Basic write, then x0 discard.
    tick(); clr(); wr(0, 5, 64'hDEAD_BEEF);
    tick(); clr(); rd(0, 5); exp_rd("x5", 0, 64'hDEAD_BEEF, 1'b0);
    wr(0, 0, 64'h1234); rd(1, 0); exp_rd("x0_same", 1, '0, 1'b0);
    tick(); clr(); rd(0, 0); exp_rd("x0", 0, '0, 1'b0);

    // Write-port collision.
    tick(); clr(); wr(0, 7, 64'h11); wr(1, 7, 64'h22);
    tick(); clr(); rd(1, 7); exp_rd("x7_prio", 1, 64'h22, 1'b0);

    // Scoreboard set / clear / same-cycle set+clear.
    tick(); clr(); issue(9);
    tick(); clr(); rd(0, 9); exp_rd("x9_busy", 0, '0, 1'b1); exp_cnt("cnt_x9", 1);
    tick(); clr(); wr(1, 9, 64'h55); RdAddr[1*AW +: AW] = 9; exp_rd("rd_dis", 1, '0, 1'b0);
    tick(); clr(); rd(0, 9); exp_rd("x9_wb", 0, 64'h55, 1'b0); exp_cnt("cnt_wb", 0);
    tick(); clr(); issue(9); wr(0, 9, 64'h66);
    tick(); clr(); rd(0, 9); exp_rd("x9_iss_wb", 0, 64'h66, 1'b1); exp_cnt("cnt_iss_wb", 1);
    tick(); clr(); wr(0, 9, 64'h77);
    tick(); clr(); rd(1, 9); exp_rd("x9_clr", 1, 64'h77, 1'b0); exp_cnt("cnt_clr", 0);

    // Three producers, then flush with a dropped issue.
    tick(); clr(); issue(3);
    tick(); clr(); issue(4);
    tick(); clr(); issue(6);
    tick(); clr(); exp_cnt("cnt3", 3); rd(0, 4); exp_rd("x4_busy", 0, '0, 1'b1);
    Flush = 1'b1; issue(8);
    tick(); clr(); exp_cnt("cnt_flush", 0);
    rd(0, 8); exp_rd("x8_flush", 0, '0, 1'b0);
    rd(1, 3); exp_rd("x3_flush", 1, '0, 1'b0);
    tick(); clr(); issue(0);
    tick(); clr(); exp_cnt("cnt_x0_iss", 0); rd(0, 0); exp_rd("x0_iss", 0, '0, 1'b0);

    // Same-cycle write and read.
    tick(); clr(); wr(0, 10, 64'hA);
    tick(); clr(); wr(0, 10, 64'hB); rd(1, 10);
`ifdef REGFILE_BYPASS_EN
    exp_rd("x10_same", 1, 64'hB, 1'b0);
`else
    exp_rd("x10_same", 1, 64'hA, 1'b0);
`endif
    tick(); clr(); rd(1, 10); exp_rd("x10_next", 1, 64'hB, 1'b0);
    tick(); clr(); issue(10); wr(1, 10, 64'hC); rd(0, 10);
`ifdef REGFILE_BYPASS_EN
    exp_rd("x10_iss_byp", 0, 64'hC, 1'b1);
`else
    exp_rd("x10_iss_byp", 0, 64'hB, 1'b0);
`endif
    tick(); clr(); rd(0, 10); exp_rd("x10_c", 0, 64'hC, 1'b1); exp_cnt("cnt_x10", 1);

    // Mid-operation reset drops in-flight write and issue.
    tick(); clr(); wr(0, 11, 64'hFF); issue(12); rd(0, 5); rd(1, 7);
    Rst = 1'b0;
    exp_rd("rst_x5", 0, '0, 1'b0); exp_rd("rst_x7", 1, '0, 1'b0); exp_cnt("rst_mid_cnt", 0);
    tick(); clr(); Rst = 1'b1;
    rd(0, 11); exp_rd("x11_lost", 0, '0, 1'b0);
    rd(1, 12); exp_rd("x12_lost", 1, '0, 1'b0);
    exp_cnt("cnt_after_rst", 0);

    tick(); clr();
    tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
